// File: rtl/note_sched_pkg.sv
// Shared types and constants for the note mod-12 scheduler.
package note_sched_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Note holder width; holds any 8-bit input, including illegal notes > 127.
  localparam int NOTE_W = 8;

  // Result field widths: pitch class 0..11, octave 0..10.
  localparam int PC_W  = 4;
  localparam int OCT_W = 4;

  // Divisor and the largest legal MIDI note, typed to the holder width.
  localparam logic [NOTE_W-1:0] NOTE_MOD = 8'd12;
  localparam logic [NOTE_W-1:0] MIDI_MAX = 8'd127;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: first set request at or above ptr_i,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   grant_idx_o,
  output logic               any_o
);

  logic             found_c;
  logic [IDX_W-1:0] idx_c;

  // Scan requesters in priority order starting from the pointer.
  always_comb begin
    logic [IDX_W:0] sum;
    found_c = 1'b0;
    idx_c   = '0;
    sum     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (!found_c && req_i[sum[IDX_W-1:0]]) begin
        found_c = 1'b1;
        idx_c   = sum[IDX_W-1:0];
      end
    end
  end

  // One-hot decode of the winning index.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant_o[gi] = found_c && (idx_c == IDX_W'(gi));
    end
  endgenerate

  assign grant_idx_o = idx_c;
  assign any_o       = found_c;

endmodule

// File: rtl/note_mod_scheduler.sv
// Shares one iterative mod-12 / div-12 engine among NUM_REQ requesters.
// Grants round-robin, subtracts 12 per cycle, and reports pitch class and
// octave (or an error for notes above 127) as a one-cycle result pulse.
module note_mod_scheduler
  import note_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [NUM_REQ-1:0]                 req_valid_in,
  input  logic [NUM_REQ-1:0][NOTE_W-1:0]     req_note_in,
  output logic [NUM_REQ-1:0]                 req_ready_out,
  output logic                               result_valid_out,
  output logic [$clog2(NUM_REQ)-1:0]         result_id_out,
  output logic [PC_W-1:0]                    pitch_class_out,
  output logic [OCT_W-1:0]                   octave_out,
  output logic                               err_out,
  output logic                               busy_out
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_e state_q, state_d;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NOTE_W-1:0]  holder_q, holder_d;
  logic [OCT_W-1:0]   oct_cnt_q, oct_cnt_d;
  logic [IDX_W-1:0]   id_q, id_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               res_valid_q, res_valid_d;
  logic [IDX_W-1:0]   res_id_q, res_id_d;
  logic [PC_W-1:0]    pitch_q, pitch_d;
  logic [OCT_W-1:0]   octave_q, octave_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               grant_any_c;

  // Illegal notes bypass the divide loop entirely.
  logic note_bad_c;
  logic note_small_c;
  assign note_bad_c   = holder_q > MIDI_MAX;
  assign note_small_c = holder_q < NOTE_MOD;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i       (req_valid_in),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant_c),
    .grant_idx_o (grant_idx_c),
    .any_o       (grant_any_c)
  );

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: grant, iterate until remainder < 12, report, return.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (grant_any_c) state_d = ST_CALC;
      ST_CALC: if (note_bad_c || note_small_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values; pulses default low.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    holder_d    = holder_q;
    oct_cnt_d   = oct_cnt_q;
    id_d        = id_q;
    ready_d     = '0;
    res_valid_d = 1'b0;
    err_d       = 1'b0;
    res_id_d    = res_id_q;
    pitch_d     = pitch_q;
    octave_d    = octave_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_any_c) begin
          holder_d  = req_note_in[grant_idx_c];
          id_d      = grant_idx_c;
          oct_cnt_d = '0;
          ready_d   = grant_c;
          rr_ptr_d  = (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0
                                                          : grant_idx_c + 1'b1;
        end
      end
      ST_CALC: begin
        if (note_bad_c) begin
          res_valid_d = 1'b1;
          err_d       = 1'b1;
          res_id_d    = id_q;
          pitch_d     = '0;
          octave_d    = '0;
        end else if (!note_small_c) begin
          holder_d  = holder_q - NOTE_MOD;
          oct_cnt_d = oct_cnt_q + 1'b1;
        end else begin
          res_valid_d = 1'b1;
          res_id_d    = id_q;
          pitch_d     = holder_q[PC_W-1:0];
          octave_d    = oct_cnt_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q    <= '0;
      holder_q    <= '0;
      oct_cnt_q   <= '0;
      id_q        <= '0;
      ready_q     <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      pitch_q     <= '0;
      octave_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      holder_q    <= holder_d;
      oct_cnt_q   <= oct_cnt_d;
      id_q        <= id_d;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      pitch_q     <= pitch_d;
      octave_q    <= octave_d;
      err_q       <= err_d;
    end
  end

  assign req_ready_out    = ready_q;
  assign result_valid_out = res_valid_q;
  assign result_id_out    = res_id_q;
  assign pitch_class_out  = pitch_q;
  assign octave_out       = octave_q;
  assign err_out          = err_q;
  assign busy_out         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_note_mod_scheduler.sv
// Directed bench for note_mod_scheduler with hand-computed expectations.
module tb_note_mod_scheduler;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      req_valid = '0;
  logic [3:0][7:0] req_note = '0;
  logic [3:0]      req_ready;
  logic            result_valid;
  logic [1:0]      result_id;
  logic [3:0]      pitch_class;
  logic [3:0]      octave;
  logic            err;
  logic            busy;

  int tests_run    = 0;
  int tests_failed = 0;

  note_mod_scheduler #(.NUM_REQ(4)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .req_valid_in     (req_valid),
    .req_note_in      (req_note),
    .req_ready_out    (req_ready),
    .result_valid_out (result_valid),
    .result_id_out    (result_id),
    .pitch_class_out  (pitch_class),
    .octave_out       (octave),
    .err_out          (err),
    .busy_out         (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait (bounded) for the accept pulse; optionally drop that requester's valid.
  task automatic wait_grant(input string tag, input int id, input bit drop);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 4'd0 && n < 50);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    if (drop) req_valid[id] = 1'b0;
  endtask

  // Called right after wait_grant: count cycles to the result pulse and check it.
  task automatic wait_result(input string tag, input int id, input int pc,
                             input int oct, input int e, input int lat);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!result_valid && n < 40);
    $display("[TB] %s: id=%0d pitch=%0d octave=%0d err=%0d latency=%0d",
             tag, result_id, pitch_class, octave, err, n);
    check_eq({tag, "_lat"}, 32'(n), 32'(lat));
    check_eq({tag, "_id"}, 32'(result_id), 32'(id));
    check_eq({tag, "_pc"}, 32'(pitch_class), 32'(pc));
    check_eq({tag, "_oct"}, 32'(octave), 32'(oct));
    check_eq({tag, "_err"}, 32'(err), 32'(e));
    @(negedge clk);
    check_eq({tag, "_vld_off"}, 32'(result_valid), 32'd0);
    check_eq({tag, "_err_off"}, 32'(err), 32'd0);
    check_eq({tag, "_pc_hold"}, 32'(pitch_class), 32'(pc));
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic single(input string tag, input int id, input int note,
                        input int pc, input int oct, input int e, input int lat);
    req_note[id]  = 8'(note);
    req_valid[id] = 1'b1;
    wait_grant(tag, id, 1'b1);
    wait_result(tag, id, pc, oct, e, lat);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_valid", 32'(result_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_pc", 32'(pitch_class), 32'd0);
    rst = 1'b0;

    // All four valid from reset: grants 0..3 in order, notes 1..4.
    for (int k = 0; k < 4; k++) req_note[k] = 8'(k + 1);
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_grant($sformatf("rr%0d", k), k, 1'b1);
      wait_result($sformatf("rr%0d", k), k, k + 1, 0, 0, 1);
    end

    // Pointer back at 0 and fairness: ids 0 and 3 request, 0 stays asserted.
    req_note[0] = 8'd13;
    req_note[3] = 8'd25;
    req_valid = 4'b1001;
    wait_grant("fair_a", 0, 1'b0);
    wait_result("fair_a", 0, 1, 1, 0, 2);
    wait_grant("fair_b", 3, 1'b1);
    wait_result("fair_b", 3, 1, 2, 0, 3);
    wait_grant("fair_c", 0, 1'b1);
    wait_result("fair_c", 0, 1, 1, 0, 2);

    // Single request and boundaries.
    single("n60", 2, 60, 0, 5, 0, 6);
    single("n0", 1, 0, 0, 0, 0, 1);
    single("n11", 3, 11, 11, 0, 0, 1);
    single("n12", 0, 12, 0, 1, 0, 2);
    single("n127", 2, 127, 7, 10, 0, 11);

    // Illegal note.
    single("n200", 1, 200, 0, 0, 1, 1);

    // Non-zero result so the reset clearing below is visible.
    single("n77", 3, 77, 5, 6, 0, 7);

    // Reset mid-CALC on note 100; requester keeps valid high.
    req_note[0]  = 8'd100;
    req_valid[0] = 1'b1;
    wait_grant("rstmid", 0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_id", 32'(result_id), 32'd0);
    check_eq("rstmid_pc", 32'(pitch_class), 32'd0);
    check_eq("rstmid_oct", 32'(octave), 32'd0);
    check_eq("rstmid_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("rstmid_novld", 32'(result_valid), 32'd0);
    end
    rst = 1'b0;
    wait_grant("regrant", 0, 1'b1);
    wait_result("regrant", 0, 4, 8, 0, 9);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/note_mod_scheduler.md
NOTE_MOD_SCHEDULER -- requirements
Module: note_mod_scheduler

Interface
REQ-001 The block SHALL have one parameter: NUM_REQ, default 4, the number of requesters sharing the mod-12 engine (range 2..8).
REQ-002 clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_in  input  1  reset, asynchronous and active-high.
REQ-004 req_valid_in  input  NUM_REQ  per-requester note pending; held high until accepted.
REQ-005 req_note_in  input  NUM_REQ x 8  per-requester MIDI note number; stable while valid.
REQ-006 req_ready_out  output  NUM_REQ  registered one-hot, 1-cycle accept pulse to the granted requester.
REQ-007 result_valid_out  output  1  1-cycle pulse marking valid result outputs.
REQ-008 result_id_out  output  clog2(NUM_REQ)  index of the requester whose note produced the result.
REQ-009 pitch_class_out  output  4  note mod 12 (0..11).
REQ-010 octave_out  output  4  note div 12 (0..10).
REQ-011 err_out  output  1  qualifies result_valid_out; note exceeded 127.
REQ-012 busy_out  output  1  high in every state except IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE; reset state IDLE.
REQ-014 In IDLE with any req_valid_in bit high, the block SHALL grant one requester by round-robin, searching from rr_ptr upward modulo NUM_REQ.
REQ-015 At the grant edge the block SHALL capture the note into an 8-bit holder and the index into an id register, clear the octave counter, set rr_ptr to (winner+1) mod NUM_REQ, pulse req_ready_out[winner] for the following cycle, and enter CALC.
REQ-016 In IDLE with no valid requests, state, rr_ptr and all outputs SHALL hold.
REQ-017 In CALC, if holder >= 12, holder SHALL decrease by 12 and the octave counter increment by 1 each cycle; otherwise the FSM SHALL enter DONE.
REQ-018 On the CALC-to-DONE edge pitch_class_out, octave_out, result_id_out and err_out SHALL be registered, and result_valid_out SHALL be high for exactly the DONE cycle, then the FSM returns to IDLE.
REQ-019 Latency SHALL be q+1 cycles from the grant edge to the result_valid_out cycle, where q = note div 12 (note 0: 1 cycle; note 127: 11 cycles).
REQ-020 A captured note > 127 SHALL skip iteration: DONE on the next edge, err_out=1, pitch_class_out=0, octave_out=0.
REQ-021 A new grant SHALL occur no earlier than the IDLE cycle after DONE; a request arriving during CALC/DONE waits with no loss.
REQ-022 Requests deasserted before grant SHALL be ignored without error; requester inputs are not sampled outside IDLE.
REQ-023 Outside the DONE cycle result_valid_out=0 and err_out=0; pitch_class_out, octave_out and result_id_out hold their last values.

Reset
REQ-024 Asserting rst_in SHALL immediately force: state IDLE, rr_ptr 0, holder 0, octave counter 0, req_ready_out 0, result_valid_out 0, result_id_out 0, pitch_class_out 0, octave_out 0, err_out 0, busy_out 0.
REQ-025 Reset during CALC or DONE SHALL discard the in-flight note with no result pulse; a requester still holding valid is granted anew after reset release.

Structure
REQ-026 Package note_sched_pkg SHALL hold the state enum, NOTE_MOD=12, MIDI_MAX=127 and the octave/pitch widths.
REQ-027 One combinational sub-module, rr_arbiter (request vector and pointer in, one-hot grant and index out), SHALL implement the round-robin selection; the iterative divide stays in the top FSM.

Verification
REQ-028 Single request: id 2 sends note 60 -> ready[2] pulse; 6 cycles after the grant edge result: id=2, pitch=0, octave=5, err=0.
REQ-029 Boundaries: notes 0, 11, 12, 127 -> (0,0) in 1 cycle, (11,0) in 1, (0,1) in 2, (7,10) in 11.
REQ-030 All four valid from reset with notes 1,2,3,4 -> grants ids 0,1,2,3 in order; rr_ptr 0 after the fourth; results in the same order.
REQ-031 Fairness: id 0 re-requests immediately after each accept while id 3 waits -> next grant goes to id 3, not id 0.
REQ-032 Note 200 from id 1 -> result next cycle with err=1, pitch=0, octave=0, id=1.
REQ-033 rst_in pulsed mid-CALC on note 100 -> outputs zero at once, no result pulse; id still valid is re-granted and yields (4,8).
